// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph table (active low, bit6=a .. bit0=g) used by both
// the hex-to-segment encoder and the scan reader, plus the reader's FSM states.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'b1111111;

  localparam seg7_t SEG7_GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } scan_state_t;

  function automatic seg7_t seg7_encode(input logic [3:0] nibble);
    return SEG7_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Display bus as seen by the scan reader, plus the decoded readback results.
interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);

  seg7_pkg::seg7_t         seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    frame_valid;
  logic                    pat_err;
  logic [2:0]              err_digit;
  logic                    err_sticky;

  modport master (
    output seg_n, an_n, clr,
    input  value, blank_mask, frame_valid, pat_err, err_digit, err_sticky
  );

  modport slave (
    input  seg_n, an_n, clr,
    output value, blank_mask, frame_valid, pat_err, err_digit, err_sticky
  );

endinterface

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse of the glyph table: segment pattern back to a hex nibble,
// with blank and legality flags.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  seg7_t      seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_legal
);

  always_comb begin
    nibble   = 4'h0;
    is_blank = (seg == SEG7_BLANK);
    is_legal = (seg == SEG7_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_GLYPH[i]) begin
        nibble   = 4'(i);
        is_legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Watches a multiplexed active-low 7-segment bus, captures each digit once it has
// settled, and publishes a complete decoded display word per full frame.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_reader_if.slave bus
);

  seg7_t                   seg_meta_reg, seg_sync_reg, seg_prev_reg;
  logic [NUM_DIGITS-1:0]   an_meta_reg, an_sync_reg, an_prev_reg;
  scan_state_t             state_reg;
  logic [7:0]              cnt_reg;
  logic [NUM_DIGITS-1:0]   seen_reg;
  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [NUM_DIGITS-1:0]   blank_mask_reg;
  logic                    frame_valid_reg, pat_err_reg, err_sticky_reg;
  logic [2:0]              err_digit_reg;

  logic [4*NUM_DIGITS-1:0] shadow_word;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic                    changed, an_onehot, capture_en;
  logic [2:0]              digit_idx;
  logic [3:0]              dec_nibble;
  logic                    dec_blank, dec_legal;

  assign changed    = (seg_sync_reg != seg_prev_reg) || (an_sync_reg != an_prev_reg);
  assign an_onehot  = $onehot(~an_sync_reg);
  assign capture_en = (state_reg == ST_CAPTURE) && !bus.clr;

  // Decode the settled sample (prev), which is stable even if the bus moves during CAPTURE.
  seg7_pattern_decoder u_dec (
    .seg      (seg_prev_reg),
    .nibble   (dec_nibble),
    .is_blank (dec_blank),
    .is_legal (dec_legal)
  );

  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_prev_reg[i]) digit_idx = 3'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
      logic [3:0] nib_reg;
      logic       blank_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          nib_reg   <= 4'h0;
          blank_reg <= 1'b0;
        end else if (capture_en && dec_legal && !an_prev_reg[gi]) begin
          nib_reg   <= dec_nibble;
          blank_reg <= dec_blank;
        end
      end
      assign shadow_word[4*gi +: 4] = nib_reg;
      assign shadow_blank[gi]       = blank_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_reg    <= SEG7_BLANK;
      seg_sync_reg    <= SEG7_BLANK;
      seg_prev_reg    <= SEG7_BLANK;
      an_meta_reg     <= '1;
      an_sync_reg     <= '1;
      an_prev_reg     <= '1;
      state_reg       <= ST_IDLE;
      cnt_reg         <= 8'd0;
      seen_reg        <= '0;
      value_reg       <= '0;
      blank_mask_reg  <= '0;
      frame_valid_reg <= 1'b0;
      pat_err_reg     <= 1'b0;
      err_digit_reg   <= 3'd0;
      err_sticky_reg  <= 1'b0;
    end else begin
      seg_meta_reg    <= bus.seg_n;
      seg_sync_reg    <= seg_meta_reg;
      seg_prev_reg    <= seg_sync_reg;
      an_meta_reg     <= bus.an_n;
      an_sync_reg     <= an_meta_reg;
      an_prev_reg     <= an_sync_reg;
      frame_valid_reg <= 1'b0;
      pat_err_reg     <= 1'b0;

      // A capture can never land in the same cycle as completion, so seen has one writer per cycle.
      if (&seen_reg) begin
        value_reg       <= shadow_word;
        blank_mask_reg  <= shadow_blank;
        frame_valid_reg <= 1'b1;
        seen_reg        <= '0;
      end

      if (bus.clr) begin
        err_sticky_reg <= 1'b0;
        seen_reg       <= '0;
        state_reg      <= ST_IDLE;
        cnt_reg        <= 8'd0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (an_onehot) begin
              state_reg <= ST_SETTLE;
              cnt_reg   <= 8'd0;
            end
          end
          ST_SETTLE: begin
            if (!an_onehot) begin
              state_reg <= ST_IDLE;
            end else if (changed) begin
              cnt_reg <= 8'd0;
            end else if (cnt_reg == 8'(SETTLE_CYCLES - 1)) begin
              state_reg <= ST_CAPTURE;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
          ST_CAPTURE: begin
            if (dec_legal) begin
              seen_reg <= seen_reg | ~an_prev_reg;
            end else begin
              pat_err_reg    <= 1'b1;
              err_digit_reg  <= digit_idx;
              err_sticky_reg <= 1'b1;
            end
            state_reg <= ST_HOLD;
          end
          ST_HOLD: begin
            if (changed) state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.value       = value_reg;
  assign bus.blank_mask  = blank_mask_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.pat_err     = pat_err_reg;
  assign bus.err_digit   = err_digit_reg;
  assign bus.err_sticky  = err_sticky_reg;

endmodule
